// File: rtl/data_mem_stage_pkg.sv
// Shared definitions for the data memory stage: widths, FSM encoding,
// decoded operation type and the byte-lane merge helper.
package data_mem_stage_pkg;

   localparam int DATA_BITS      = 32;
   localparam int WORD_ADDR_BITS = 10;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      MERGE,
      FIN
   } state_e;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_LOAD,
      OP_STORE
   } op_e;

   // Replace one byte lane of a word; used for read-modify-write byte stores.
   function automatic logic [DATA_BITS-1:0] merge_byte(input logic [DATA_BITS-1:0] word,
                                                       input logic [1:0]           lane,
                                                       input logic [7:0]           b);
      logic [DATA_BITS-1:0] r;
      r = word;
      case (lane)
         2'd0:    r[7:0]   = b;
         2'd1:    r[15:8]  = b;
         2'd2:    r[23:16] = b;
         default: r[31:24] = b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/data_mem_stage_if.sv
// Request/response bus between the pipeline and the data memory stage.
interface data_mem_stage_if #(
   parameter int DATA_BITS = data_mem_stage_pkg::DATA_BITS
);
   logic                 req;
   logic                 MemRead;
   logic                 MemWrite;
   logic                 ByteOp;
   logic [DATA_BITS-1:0] addr;
   logic [DATA_BITS-1:0] wdata;
   logic [DATA_BITS-1:0] mem_out;
   logic [1:0]           addr_byte;
   logic                 busy;
   logic                 done;
   logic                 err;

   modport master (
      output req, MemRead, MemWrite, ByteOp, addr, wdata,
      input  mem_out, addr_byte, busy, done, err
   );

   modport slave (
      input  req, MemRead, MemWrite, ByteOp, addr, wdata,
      output mem_out, addr_byte, busy, done, err
   );
endinterface

// File: rtl/data_mem_stage_sync_ram_sp.sv
// Single-port synchronous RAM: one write enable, read-first, registered
// read data with one cycle of latency.
module sync_ram_sp #(
   parameter int DATA_BITS = 32,
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [DATA_BITS-1:0] wdata,
   output logic [DATA_BITS-1:0] rdata
);

   logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

   // Write on enable and register the addressed word every cycle.
   // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_stage.sv
// Data memory stage: accepts one load/store at a time, performs word
// accesses directly and byte stores as read-modify-write on the RAM.
module data_mem_stage #(
   parameter int DATA_BITS      = data_mem_stage_pkg::DATA_BITS,
   parameter int WORD_ADDR_BITS = data_mem_stage_pkg::WORD_ADDR_BITS
) (
   input  logic              clk,
   input  logic              rst,
   data_mem_stage_if.slave   bus
);
   import data_mem_stage_pkg::*;

   state_e                    state, state_nxt;
   op_e                       in_op, op_q;
   logic                      in_err, err_q;
   logic                      accept, load_fin;
   logic                      ram_we;
   logic [WORD_ADDR_BITS-1:0] ram_addr, word_q;
   logic [DATA_BITS-1:0]      ram_wdata, ram_rdata, merged;
   logic [DATA_BITS-1:0]      mem_out_q;
   logic [1:0]                addr_byte_q;
   logic [7:0]                wbyte_q;
   logic                      unused_addr_hi;

   // Upper address bits select nothing: the RAM index wraps.
   assign unused_addr_hi = ^bus.addr[DATA_BITS-1:WORD_ADDR_BITS+2];

   // Decode the incoming request; misaligned word access or read+write is rejected.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      in_op  = OP_NONE;
      in_err = 1'b0;
      if (bus.MemRead && bus.MemWrite) begin
         in_err = 1'b1;
      end else if (bus.MemRead) begin
         in_op = OP_LOAD;
      end else if (bus.MemWrite) begin
         in_op = OP_STORE;
      end
      if (in_op != OP_NONE && !bus.ByteOp && bus.addr[1:0] != 2'b00) begin
         in_err = 1'b1;
      end
      if (in_err) begin
         in_op = OP_NONE;
      end
   end

   assign merged = merge_byte(ram_rdata, addr_byte_q, wbyte_q);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and RAM control; FIN accepts a new request just like IDLE.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      load_fin  = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = word_q;
      ram_wdata = merged;
      case (state)
         IDLE, FIN: begin
            state_nxt = IDLE;
            ram_addr  = bus.addr[WORD_ADDR_BITS+1:2];
            if (bus.req) begin
               accept = 1'b1;
               if (in_err || in_op == OP_NONE) begin
                  state_nxt = FIN;
               end else if (in_op == OP_LOAD || bus.ByteOp) begin
                  state_nxt = RD;
               end else begin
                  state_nxt = FIN;
                  ram_we    = 1'b1;
                  ram_wdata = bus.wdata;
               end
            end
         end
         RD: begin
            // The byte-store path re-reads the same word so rdata is valid in MERGE.
            if (op_q == OP_LOAD) begin
               state_nxt = FIN;
               load_fin  = 1'b1;
            end else begin
               state_nxt = MERGE;
            end
         end
         MERGE: begin
            state_nxt = FIN;
            ram_we    = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Capture request fields on acceptance and the load result on RD->FIN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q        <= OP_NONE;
         err_q       <= 1'b0;
         word_q      <= '0;
         wbyte_q     <= '0;
         addr_byte_q <= '0;
         mem_out_q   <= '0;
      end else begin
         if (accept) begin
            op_q        <= in_op;
            err_q       <= in_err;
            word_q      <= bus.addr[WORD_ADDR_BITS+1:2];
            wbyte_q     <= bus.wdata[7:0];
            addr_byte_q <= bus.addr[1:0];
         end
         if (load_fin) begin
            mem_out_q <= ram_rdata;
         end
      end
   end

   sync_ram_sp #(
      .DATA_BITS (DATA_BITS),
      .ADDR_BITS (WORD_ADDR_BITS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign bus.mem_out   = mem_out_q;
   assign bus.addr_byte = addr_byte_q;
   assign bus.busy      = (state == RD) || (state == MERGE);
   assign bus.done      = (state == FIN);
   assign bus.err       = (state == FIN) && err_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: word/byte loads and stores, rejects,
// back-to-back acceptance in FIN, request hold during busy, and mid-op reset.
module tb_data_mem_stage;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;

   data_mem_stage_if #(.DATA_BITS(32)) bus ();

   data_mem_stage #(
      .DATA_BITS      (32),
      .WORD_ADDR_BITS (10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present a request at the falling edge, hold it across one rising edge.
   task automatic issue(input logic rd, input logic wr, input logic bop,
                        input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.req      = 1'b1;
      bus.MemRead  = rd;
      bus.MemWrite = wr;
      bus.ByteOp   = bop;
      bus.addr     = a;
      bus.wdata    = d;
      @(posedge clk);
      #1;
      bus.req      = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.ByteOp   = 1'b0;
   endtask

   // Called 1 time unit after the acceptance edge; done must appear exactly
   // 'edges' rising edges after acceptance (acceptance edge counts as one).
   task automatic expect_done(input string tag, input int edges, input logic exp_err);
      for (int i = 1; i <= edges; i++) begin
         if (i > 1) begin
            @(posedge clk);
            #1;
         end
         check({tag, "_done"}, 32'(bus.done), 32'(i == edges));
         check({tag, "_busy"}, 32'(bus.busy), 32'(i != edges));
      end
      check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
   endtask

   task automatic do_load(input string tag, input logic bop, input logic [31:0] a,
                          input logic [31:0] exp);
      issue(1'b1, 1'b0, bop, a, 32'h0);
      expect_done(tag, 2, 1'b0);
      check({tag, "_mem_out"}, bus.mem_out, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      n_checks     = 0;
      n_fails      = 0;
      rst          = 1'b1;
      bus.req      = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.ByteOp   = 1'b0;
      bus.addr     = '0;
      bus.wdata    = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_out",   bus.mem_out,          32'h0);
      check("rst_addr_byte", 32'(bus.addr_byte),   32'h0);
      check("rst_busy",      32'(bus.busy),        32'h0);
      check("rst_done",      32'(bus.done),        32'h0);
      check("rst_err",       32'(bus.err),         32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Word store then word load of the same word.
      issue(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
      expect_done("wst10", 1, 1'b0);
      do_load("wld10", 1'b0, 32'h10, 32'hDEADBEEF);

      // Byte store into lane 2, mem_out untouched by the store, then reload.
      issue(1'b0, 1'b1, 1'b1, 32'h12, 32'h000000AA);
      expect_done("bst12", 3, 1'b0);
      check("bst12_keep", bus.mem_out, 32'hDEADBEEF);
      do_load("wld10b", 1'b0, 32'h10, 32'hDEAABEEF);

      // Misaligned word load is rejected; byte load of same address is fine.
      issue(1'b1, 1'b0, 1'b0, 32'h13, 32'h0);
      expect_done("wld13", 1, 1'b1);
      check("wld13_keep", bus.mem_out, 32'hDEAABEEF);
      do_load("bld13", 1'b1, 32'h13, 32'hDEAABEEF);
      check("bld13_lane", 32'(bus.addr_byte), 32'h3);

      // Request held high through a byte store; fields change while busy.
      issue(1'b0, 1'b1, 1'b0, 32'h14, 32'h01020304);
      expect_done("wst14", 1, 1'b0);
      @(negedge clk);
      bus.req      = 1'b1;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b1;
      bus.ByteOp   = 1'b1;
      bus.addr     = 32'h14;
      bus.wdata    = 32'h00000055;
      @(posedge clk);
      #1;
      bus.ByteOp   = 1'b0;
      bus.addr     = 32'h18;
      bus.wdata    = 32'hCAFEF00D;
      check("hold_e1_busy", 32'(bus.busy), 32'h1);
      @(posedge clk);
      #1;
      check("hold_e2_busy", 32'(bus.busy), 32'h1);
      check("hold_e2_done", 32'(bus.done), 32'h0);
      @(posedge clk);
      #1;
      check("hold_e3_done", 32'(bus.done), 32'h1);
      check("hold_e3_busy", 32'(bus.busy), 32'h0);
      @(posedge clk);
      #1;
      bus.req      = 1'b0;
      bus.MemWrite = 1'b0;
      check("hold_e4_done", 32'(bus.done), 32'h1);
      check("hold_e4_err",  32'(bus.err),  32'h0);
      do_load("ld14", 1'b0, 32'h14, 32'h01020355);
      do_load("ld18", 1'b0, 32'h18, 32'hCAFEF00D);

      // Reset in the RD cycle of a byte store into the word at 0x10.
      issue(1'b0, 1'b1, 1'b1, 32'h11, 32'h00000077);
      check("rrd_busy",      32'(bus.busy),      32'h1);
      check("rrd_addr_byte", 32'(bus.addr_byte), 32'h1);
      rst = 1'b1;
      #1;
      check("rrd_mem_out",   bus.mem_out,        32'h0);
      check("rrd_addr_byte0", 32'(bus.addr_byte), 32'h0);
      check("rrd_busy0",     32'(bus.busy),      32'h0);
      check("rrd_done0",     32'(bus.done),      32'h0);
      check("rrd_err0",      32'(bus.err),       32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      do_load("rrd_ld10", 1'b0, 32'h10, 32'hDEAABEEF);

      // Read+write together is rejected without touching memory.
      issue(1'b0, 1'b1, 1'b0, 32'h20, 32'h600DF00D);
      expect_done("wst20", 1, 1'b0);
      issue(1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678);
      expect_done("rw20", 1, 1'b1);
      do_load("ld20", 1'b0, 32'h20, 32'h600DF00D);

      // Misaligned word store writes nothing.
      issue(1'b0, 1'b1, 1'b0, 32'h22, 32'h11111111);
      expect_done("wst22", 1, 1'b1);
      do_load("ld20b", 1'b0, 32'h20, 32'h600DF00D);

      // No-op request completes with no error and no side effect.
      issue(1'b0, 1'b0, 1'b0, 32'h20, 32'hFFFFFFFF);
      expect_done("nop", 1, 1'b0);
      check("nop_keep", bus.mem_out, 32'h600DF00D);

      // Address bits above the RAM index are ignored: 0x1010 aliases 0x10.
      issue(1'b0, 1'b1, 1'b0, 32'h00001010, 32'h13572468);
      expect_done("wst1010", 1, 1'b0);
      do_load("ld10alias", 1'b0, 32'h10, 32'h13572468);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
      $finish;
   end

endmodule
